// File: rtl/i8080_pkg.sv
// Shared 8080 fetch definitions: opcode constants, fetch FSM states and the
// opcode-to-length table used by fetch and by disassembly/trace tooling.
package i8080_pkg;

   localparam logic [7:0] OP_NOP   = 8'h00;
   localparam logic [7:0] OP_LXI_H = 8'h21;
   localparam logic [7:0] OP_MVI_A = 8'h3E;
   localparam logic [7:0] OP_HLT   = 8'h76;
   localparam logic [7:0] OP_JMP   = 8'hC3;
   localparam logic [7:0] OP_RET   = 8'hC9;
   localparam logic [7:0] OP_CALL  = 8'hCD;
   localparam logic [7:0] OP_RST7  = 8'hFF;

   typedef enum logic [2:0] {
      ISSUE,
      WAIT,
      CAPTURE,
      PRESENT,
      HALTED
   } fetch_state_e;

   // CB/DD/ED/FD are undocumented aliases of JMP/CALL and take 3 bytes.
   function automatic logic [1:0] instr_len_f(input logic [7:0] op);
      logic [1:0] len;
      case (op)
         8'h06, 8'h0E, 8'h16, 8'h1E, 8'h26, 8'h2E, 8'h36, 8'h3E,
         8'hC6, 8'hCE, 8'hD6, 8'hDE, 8'hE6, 8'hEE, 8'hF6, 8'hFE,
         8'hD3, 8'hDB:
            len = 2'd2;
         8'h01, 8'h11, 8'h21, 8'h31,
         8'h22, 8'h2A, 8'h32, 8'h3A,
         8'hC2, 8'hC3, 8'hCA, 8'hD2, 8'hDA, 8'hE2, 8'hEA, 8'hF2, 8'hFA,
         8'hC4, 8'hCC, 8'hCD, 8'hD4, 8'hDC, 8'hE4, 8'hEC, 8'hF4, 8'hFC,
         8'hCB, 8'hDD, 8'hED, 8'hFD:
            len = 2'd3;
         default:
            len = 2'd1;
      endcase
      return len;
   endfunction

endpackage

// File: rtl/fetch_len_decode.sv
// Combinational 8080 opcode-to-instruction-length lookup.
module fetch_len_decode
   import i8080_pkg::*;
(
   input  logic [7:0] opcode_i,
   output logic [1:0] len_o
);

   assign len_o = instr_len_f(opcode_i);

endmodule

// File: rtl/fetch_unit.sv
// 8080 instruction fetch stage: issue, wait for memory, capture, present to decode.
// Define FETCH_TRACE_EN to print a line per capture and per redirect.
module fetch_unit
   import i8080_pkg::*;
#(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter int          MEM_LAT  = 2
) (
   input  logic         clk,
   input  logic         reset,
   output logic [15:0]  raddr0,
   input  logic [23:0]  rdata0,
   output logic         instr_valid,
   input  logic         instr_ready,
   output logic [23:0]  instr,
   output logic [1:0]   instr_len,
   output logic [15:0]  instr_pc,
   output logic [15:0]  next_pc,
   input  logic         redirect_valid,
   input  logic [15:0]  redirect_pc,
   output logic         halted,
   output fetch_state_e dbg_state_o
);

   // Handshake: an instruction transfers on a posedge where instr_valid && instr_ready;
   // instr/instr_len/instr_pc/next_pc stay stable while instr_valid && !instr_ready.

   fetch_state_e state_q, state_d;
   logic [1:0]   cnt_q, cnt_d;
   logic [15:0]  fetch_pc_q, fetch_pc_d;
   logic [15:0]  raddr0_q, raddr0_d;
   logic         valid_q, valid_d;
   logic         halted_q, halted_d;
   logic [23:0]  instr_q, instr_d;
   logic [1:0]   len_q, len_d;
   logic [15:0]  pc_q, pc_d;
   logic [15:0]  next_pc_q, next_pc_d;
   logic [1:0]   dec_len;

   fetch_len_decode u_len_decode (
      .opcode_i (rdata0[23:16]),
      .len_o    (dec_len)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      fetch_pc_d = fetch_pc_q;
      raddr0_d   = fetch_pc_q;
      valid_d    = valid_q;
      halted_d   = halted_q;
      instr_d    = instr_q;
      len_d      = len_q;
      pc_d       = pc_q;
      next_pc_d  = next_pc_q;

      case (state_q)
         ISSUE: begin
            cnt_d   = 2'd0;
            state_d = WAIT;
         end
         WAIT: begin
            // Counter counts edges since the address became stable; the ISSUE edge is the first.
            cnt_d = cnt_q + 2'd1;
            if (int'(cnt_q) + 1 >= MEM_LAT - 1) state_d = CAPTURE;
         end
         CAPTURE: begin
            instr_d    = rdata0;
            pc_d       = fetch_pc_q;
            len_d      = dec_len;
            fetch_pc_d = fetch_pc_q + {14'd0, dec_len};
            next_pc_d  = fetch_pc_q + {14'd0, dec_len};
            valid_d    = 1'b1;
            if (rdata0[23:16] == OP_HLT) begin
               halted_d = 1'b1;
               state_d  = HALTED;
            end else begin
               state_d  = PRESENT;
            end
         end
         PRESENT: begin
            if (instr_ready) begin
               valid_d = 1'b0;
               state_d = ISSUE;
            end
         end
         HALTED: begin
            if (instr_ready) valid_d = 1'b0;
         end
         default: state_d = ISSUE;
      endcase

      // Redirect wins over capture and accept; the new address is driven straight away
      // so the following ISSUE cycle already presents the target.
      if (redirect_valid) begin
         state_d    = ISSUE;
         cnt_d      = 2'd0;
         fetch_pc_d = redirect_pc;
         raddr0_d   = redirect_pc;
         valid_d    = 1'b0;
         halted_d   = 1'b0;
         instr_d    = instr_q;
         len_d      = len_q;
         pc_d       = pc_q;
         next_pc_d  = next_pc_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ISSUE;
         cnt_q      <= 2'd0;
         fetch_pc_q <= RESET_PC;
         raddr0_q   <= RESET_PC;
         valid_q    <= 1'b0;
         halted_q   <= 1'b0;
         instr_q    <= 24'd0;
         len_q      <= 2'd0;
         pc_q       <= 16'd0;
         next_pc_q  <= 16'd0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         fetch_pc_q <= fetch_pc_d;
         raddr0_q   <= raddr0_d;
         valid_q    <= valid_d;
         halted_q   <= halted_d;
         instr_q    <= instr_d;
         len_q      <= len_d;
         pc_q       <= pc_d;
         next_pc_q  <= next_pc_d;
      end
   end

`ifdef FETCH_TRACE_EN
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (state_q == CAPTURE)
            $write("fetch pc=%h op=%h len=%0d\n", fetch_pc_q, rdata0[23:16], dec_len);
         if (redirect_valid)
            $write("redirect %h\n", redirect_pc);
      end
   end
`endif

   assign raddr0      = raddr0_q;
   assign instr_valid = valid_q;
   assign instr       = instr_q;
   assign instr_len   = len_q;
   assign instr_pc    = pc_q;
   assign next_pc     = next_pc_q;
   assign halted      = halted_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a 2-edge registered memory model.
module tb_fetch_unit;
   import i8080_pkg::*;

   logic         clk;
   logic         reset;
   logic [15:0]  raddr0;
   logic [23:0]  rdata0;
   logic         instr_valid;
   logic         instr_ready;
   logic [23:0]  instr;
   logic [1:0]   instr_len;
   logic [15:0]  instr_pc;
   logic [15:0]  next_pc;
   logic         redirect_valid;
   logic [15:0]  redirect_pc;
   logic         halted;
   fetch_state_e dbg_state;

   int n_vec = 0;
   int n_err = 0;

   logic [7:0]  mem [65536];
   logic [15:0] mem_addr_q;

   fetch_unit #(.RESET_PC(16'h0000), .MEM_LAT(2)) dut (
      .clk            (clk),
      .reset          (reset),
      .raddr0         (raddr0),
      .rdata0         (rdata0),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr          (instr),
      .instr_len      (instr_len),
      .instr_pc       (instr_pc),
      .next_pc        (next_pc),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halted         (halted),
      .dbg_state_o    (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   // memory: address registered on edge 1, data on edge 2
   always @(posedge clk) begin
      mem_addr_q <= raddr0;
      rdata0     <= {mem[mem_addr_q], mem[mem_addr_q + 16'd1], mem[mem_addr_q + 16'd2]};
   end

   // driver tasks
   task automatic mem_clear();
      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
   endtask

   task automatic load_straight();
      mem_clear();
      mem[0] = 8'h00; mem[1] = 8'h06; mem[2] = 8'h5A;
      mem[3] = 8'hC3; mem[4] = 8'h34; mem[5] = 8'h12;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset          = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 16'h0000;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic wait_valid(input int budget, output int cyc, output bit ok);
      ok  = 1'b0;
      cyc = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         cyc++;
         if (instr_valid) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      instr_ready = 1'b1;
      @(negedge clk);
      reset = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc = 16'h0000;
      @(negedge clk);
      @(negedge clk);
      n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b exp 0", instr_valid); end
      n_vec++; if (halted !== 1'b0) begin n_err++; $display("FAIL reset_halted got %b exp 0", halted); end
      n_vec++; if (raddr0 !== 16'h0000) begin n_err++; $display("FAIL reset_raddr0 got %h exp 0000", raddr0); end
      n_vec++; if (instr !== 24'h0) begin n_err++; $display("FAIL reset_instr got %h exp 000000", instr); end
      n_vec++; if (instr_len !== 2'd0) begin n_err++; $display("FAIL reset_len got %0d exp 0", instr_len); end
      n_vec++; if (instr_pc !== 16'h0 || next_pc !== 16'h0) begin n_err++; $display("FAIL reset_pcs got %h/%h exp 0000/0000", instr_pc, next_pc); end
      n_vec++; if (dbg_state !== ISSUE) begin n_err++; $display("FAIL reset_state got %0d exp ISSUE", dbg_state); end
      reset = 1'b0;
   endtask

   task automatic test_straight();
      int cyc; bit ok;
      logic [23:0] exp_instr [3];
      logic [15:0] exp_pc    [3];
      logic [1:0]  exp_len   [3];
      logic [15:0] exp_next  [3];
      exp_instr[0] = 24'h00065A; exp_pc[0] = 16'h0000; exp_len[0] = 2'd1; exp_next[0] = 16'h0001;
      exp_instr[1] = 24'h065AC3; exp_pc[1] = 16'h0001; exp_len[1] = 2'd2; exp_next[1] = 16'h0003;
      exp_instr[2] = 24'hC33412; exp_pc[2] = 16'h0003; exp_len[2] = 2'd3; exp_next[2] = 16'h0006;
      load_straight();
      instr_ready = 1'b1;
      do_reset();
      for (int k = 0; k < 3; k++) begin
         wait_valid(20, cyc, ok);
         n_vec++; if (!ok) begin n_err++; $display("FAIL straight_timeout idx %0d", k); end
         n_vec++; if (cyc != (k == 0 ? 3 : 4)) begin n_err++; $display("FAIL straight_latency idx %0d got %0d exp %0d", k, cyc, (k == 0 ? 3 : 4)); end
         n_vec++; if (instr !== exp_instr[k]) begin n_err++; $display("FAIL straight_instr idx %0d got %h exp %h", k, instr, exp_instr[k]); end
         n_vec++; if (instr_pc !== exp_pc[k]) begin n_err++; $display("FAIL straight_pc idx %0d got %h exp %h", k, instr_pc, exp_pc[k]); end
         n_vec++; if (instr_len !== exp_len[k]) begin n_err++; $display("FAIL straight_len idx %0d got %0d exp %0d", k, instr_len, exp_len[k]); end
         n_vec++; if (next_pc !== exp_next[k]) begin n_err++; $display("FAIL straight_next idx %0d got %h exp %h", k, next_pc, exp_next[k]); end
      end
   endtask

   task automatic test_backpressure();
      int cyc; bit ok;
      load_straight();
      instr_ready = 1'b1;
      do_reset();
      wait_valid(20, cyc, ok);
      n_vec++; if (!ok || instr_pc !== 16'h0000) begin n_err++; $display("FAIL bp_first got pc %h ok %b exp 0000", instr_pc, ok); end
      @(negedge clk);
      instr_ready = 1'b0;
      wait_valid(20, cyc, ok);
      n_vec++; if (!ok) begin n_err++; $display("FAIL bp_timeout"); end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         n_vec++;
         if (instr_valid !== 1'b1 || instr !== 24'h065AC3 || instr_pc !== 16'h0001 || instr_len !== 2'd2) begin
            n_err++;
            $display("FAIL bp_hold cyc %0d got v%b %h pc %h len %0d exp v1 065AC3 pc 0001 len 2",
                     i, instr_valid, instr, instr_pc, instr_len);
         end
      end
      instr_ready = 1'b1;
      wait_valid(20, cyc, ok);
      n_vec++; if (!ok || cyc != 4) begin n_err++; $display("FAIL bp_release_latency got %0d exp 4", cyc); end
      n_vec++; if (instr_pc !== 16'h0003 || instr !== 24'hC33412) begin n_err++; $display("FAIL bp_release got pc %h %h exp 0003 C33412", instr_pc, instr); end
   endtask

   task automatic test_redirect_race();
      int cyc; bit ok;
      load_straight();
      mem[16'h0100] = OP_MVI_A; mem[16'h0101] = 8'h77; mem[16'h0102] = 8'h00;
      instr_ready = 1'b1;
      do_reset();
      @(negedge clk);
      @(negedge clk);
      n_vec++; if (dbg_state !== CAPTURE) begin n_err++; $display("FAIL race_state got %0d exp CAPTURE", dbg_state); end
      redirect_valid = 1'b1;
      redirect_pc    = 16'h0100;
      @(negedge clk);
      redirect_valid = 1'b0;
      n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL race_dropped got %b exp 0", instr_valid); end
      n_vec++; if (raddr0 !== 16'h0100) begin n_err++; $display("FAIL race_raddr0 got %h exp 0100", raddr0); end
      wait_valid(20, cyc, ok);
      n_vec++; if (!ok || instr_pc !== 16'h0100) begin n_err++; $display("FAIL race_pc got %h ok %b exp 0100", instr_pc, ok); end
      n_vec++; if (instr !== 24'h3E7700 || instr_len !== 2'd2 || next_pc !== 16'h0102) begin n_err++; $display("FAIL race_instr got %h len %0d next %h exp 3E7700 len 2 next 0102", instr, instr_len, next_pc); end
   endtask

   task automatic test_hlt();
      int cyc; bit ok;
      mem_clear();
      mem[0] = OP_HLT;
      mem[16'h0010] = OP_LXI_H; mem[16'h0011] = 8'h34; mem[16'h0012] = 8'h12;
      instr_ready = 1'b1;
      do_reset();
      wait_valid(20, cyc, ok);
      n_vec++; if (!ok || instr[23:16] !== OP_HLT || instr_len !== 2'd1) begin n_err++; $display("FAIL hlt_instr got %h len %0d exp 76xxxx len 1", instr, instr_len); end
      n_vec++; if (halted !== 1'b1) begin n_err++; $display("FAIL hlt_halted got %b exp 1", halted); end
      @(negedge clk);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         n_vec++;
         if (halted !== 1'b1 || instr_valid !== 1'b0 || raddr0 !== 16'h0001) begin
            n_err++;
            $display("FAIL hlt_frozen cyc %0d got halted %b valid %b raddr0 %h exp 1 0 0001", i, halted, instr_valid, raddr0);
         end
      end
      redirect_valid = 1'b1;
      redirect_pc    = 16'h0010;
      @(negedge clk);
      redirect_valid = 1'b0;
      n_vec++; if (halted !== 1'b0) begin n_err++; $display("FAIL hlt_resume_halted got %b exp 0", halted); end
      wait_valid(20, cyc, ok);
      n_vec++; if (!ok || instr_pc !== 16'h0010 || instr !== 24'h213412 || instr_len !== 2'd3 || next_pc !== 16'h0013) begin
         n_err++;
         $display("FAIL hlt_resume got pc %h %h len %0d next %h exp 0010 213412 len 3 next 0013", instr_pc, instr, instr_len, next_pc);
      end
   endtask

   task automatic test_wrap();
      int cyc; bit ok;
      mem_clear();
      mem[16'hFFFE] = OP_CALL; mem[16'hFFFF] = 8'h10;
      mem[0] = 8'h20; mem[1] = 8'hC6; mem[2] = 8'h05;
      instr_ready = 1'b1;
      do_reset();
      @(negedge clk);
      n_vec++; if (dbg_state !== WAIT) begin n_err++; $display("FAIL wrap_pre_state got %0d exp WAIT", dbg_state); end
      redirect_valid = 1'b1;
      redirect_pc    = 16'hFFFE;
      @(negedge clk);
      redirect_valid = 1'b0;
      n_vec++; if (dbg_state !== ISSUE || raddr0 !== 16'hFFFE) begin n_err++; $display("FAIL wrap_restart got state %0d raddr0 %h exp ISSUE FFFE", dbg_state, raddr0); end
      wait_valid(20, cyc, ok);
      n_vec++; if (!ok || cyc != 3) begin n_err++; $display("FAIL wrap_latency got %0d exp 3", cyc); end
      n_vec++; if (instr !== 24'hCD1020 || instr_len !== 2'd3 || instr_pc !== 16'hFFFE) begin n_err++; $display("FAIL wrap_instr got %h len %0d pc %h exp CD1020 len 3 pc FFFE", instr, instr_len, instr_pc); end
      n_vec++; if (next_pc !== 16'h0001) begin n_err++; $display("FAIL wrap_next got %h exp 0001", next_pc); end
      wait_valid(20, cyc, ok);
      n_vec++; if (!ok || instr_pc !== 16'h0001 || instr !== 24'hC60500 || instr_len !== 2'd2) begin n_err++; $display("FAIL wrap_follow got pc %h %h len %0d exp 0001 C60500 len 2", instr_pc, instr, instr_len); end
   endtask

   task automatic test_reset_mid_wait();
      int cyc; bit ok;
      load_straight();
      instr_ready = 1'b1;
      do_reset();
      wait_valid(20, cyc, ok);
      n_vec++; if (!ok || instr_pc !== 16'h0000) begin n_err++; $display("FAIL rmw_first got pc %h exp 0000", instr_pc); end
      @(negedge clk);
      @(negedge clk);
      n_vec++; if (dbg_state !== WAIT || raddr0 !== 16'h0001) begin n_err++; $display("FAIL rmw_pre got state %0d raddr0 %h exp WAIT 0001", dbg_state, raddr0); end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      n_vec++; if (instr_valid !== 1'b0 || raddr0 !== 16'h0000) begin n_err++; $display("FAIL rmw_reset got valid %b raddr0 %h exp 0 0000", instr_valid, raddr0); end
      wait_valid(20, cyc, ok);
      n_vec++; if (!ok || instr_pc !== 16'h0000 || instr !== 24'h00065A || cyc != 3) begin
         n_err++;
         $display("FAIL rmw_restart got pc %h %h after %0d exp 0000 00065A after 3", instr_pc, instr, cyc);
      end
   endtask

   initial begin
      reset          = 1'b1;
      instr_ready    = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 16'h0000;
      mem_clear();
      test_reset();
      test_straight();
      test_backpressure();
      test_redirect_race();
      test_hlt();
      test_wrap();
      test_reset_mid_wait();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- 8080 instruction fetch stage; sits directly upstream of the unified memory's 3-byte instruction read port.
- Drives `raddr0` and captures `rdata0`, which holds bytes {mem[a], mem[a+1], mem[a+2]}. Opcode is at [23:16].
- Decodes instruction length (1/2/3) from the opcode and advances the PC.
- Hands each instruction to decode over a valid/ready handshake. Supports redirects (jumps, calls, returns, RST) and halts on HLT.

Parameters:
- RESET_PC, 16'h0000, PC loaded on reset.
- MEM_LAT, 2, edges from address-stable to `rdata0` valid. Memory registers the address on edge 1 and the data on edge 2. Legal values are 1 and 2.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- raddr0  out  16  instruction read address to memory (registered, equal to `fetch_pc`).
- rdata0  in  24  3-byte read data from memory.
- instr_valid  out  1  instruction output register is valid.
- instr_ready  in  1  decode accepts the instruction this cycle.
- instr  out  24  captured bytes; [23:16]=opcode, [15:8]=byte2, [7:0]=byte3. Unused bytes are passed through unmasked.
- instr_len  out  2  1, 2 or 3.
- instr_pc  out  16  address of the opcode.
- next_pc  out  16  instr_pc+instr_len mod 2^16; this is the CALL return address.
- redirect_valid  in  1  load a new PC and flush.
- redirect_pc  in  16  target PC.
- halted  out  1  fetch is stopped after HLT.

Behaviour:
- Reset, synchronous and active-high, from any state:
  - fetch_pc=RESET_PC, state=ISSUE.
  - instr_valid=0, halted=0, instr/instr_len/instr_pc/next_pc=0, raddr0=RESET_PC.
- States:
  - ISSUE: raddr0 held at fetch_pc, wait counter cleared. Next state WAIT.
  - WAIT: counter increments each cycle. When counter==MEM_LAT-1, go to CAPTURE. rdata0 is valid during CAPTURE.
  - CAPTURE: sample rdata0 into instr at the edge and set instr_pc=fetch_pc and instr_len=len(opcode). Set fetch_pc=fetch_pc+len; raddr0 follows one cycle later. Set instr_valid=1.
    - Opcode 8'h76 (HLT): go to HALTED.
    - Otherwise: go to PRESENT.
  - PRESENT: hold all outputs stable while instr_valid && !instr_ready. On instr_ready, set instr_valid=0 and go to ISSUE.
  - HALTED: instr_valid=1 until accepted, then 0; halted=1. No further reads issued. Exit only on redirect or reset.
- Latency and throughput:
  - Address stable to instr_valid is MEM_LAT+1 edges.
  - Accept to next instr_valid is MEM_LAT+2 edges.
  - Peak throughput is 1 instruction per 4 cycles at MEM_LAT=2.
- Redirect, accepted in any state:
  - fetch_pc=redirect_pc, instr_valid=0, halted=0, state=ISSUE.
  - Any read in flight is discarded. A redirect during WAIT restarts the counter.
  - Redirect outranks instr_ready and CAPTURE in the same cycle: the captured instruction is dropped, and instr_ready has no effect.
- Length table:
  - 2-byte:
    - 06,0E,16,1E,26,2E,36,3E
    - C6,CE,D6,DE,E6,EE,F6,FE
    - D3,DB
  - 3-byte:
    - 01,11,21,31
    - 22,2A,32,3A
    - C2,C3,CA,D2,DA,E2,EA,F2,FA
    - C4,CC,CD,D4,DC,E4,EC,F4,FC
    - Undocumented aliases CB,DD,ED,FD.
  - All other opcodes are 1 byte.
- Arithmetic: PC adds are 16-bit and wrap (FFFF+1 is 0000). An instruction at FFFE of length 3 gives next_pc=0001. Byte fetch past FFFF is the memory's responsibility.
- Coherence: instr reflects memory contents at the sampling edge. Stores that land between issue and capture are not tracked. Self-modifying code needs a redirect.

Optional Feature:
- FETCH_TRACE_EN defined: on each CAPTURE edge, print "fetch pc=%h op=%h len=%0d\n" with `$write`. On redirect, print "redirect %h\n".
- FETCH_TRACE_EN undefined: no simulation output, identical RTL behaviour.

Decomposition:
- Package i8080_pkg holds:
  - opcode constants (OP_HLT=8'h76, OP_JMP=8'hC3, OP_CALL=8'hCD, ...)
  - state typedef {ISSUE, WAIT, CAPTURE, PRESENT, HALTED}
  - function instr_len_f(opcode) returning 2 bits.
- One natural sub-module: fetch_len_decode, a combinational opcode-to-length table. It is shared later with the disassembler/trace tooling.

Test Plan:
- Straight line: reset with mem[0..5]=00,06,5A,C3,34,12 and instr_ready=1.
  - Outputs in order: {pc 0000, len1, op00}, {0001, len2, 065A__}, {0003, len3, C33412}.
  - Each instr_valid rises MEM_LAT+2 cycles after the previous accept.
- Backpressure: hold instr_ready=0 for 10 cycles on instr at 0001 → instr, instr_pc, instr_len stay stable, no new capture. Release → next_pc=0003 fetched.
- Redirect race: assert redirect_valid with redirect_pc=0100 in the same cycle as CAPTURE and instr_ready=1 → no instruction emitted from the old PC. First instr_pc=0100.
- HLT: mem[0]=76, accept it → halted=1 and raddr0 frozen for 20 cycles. Redirect to 0010 → halted=0 and fetch resumes at 0010.
- Wrap: redirect to FFFE with mem[FFFE]=CD → instr_len=3, next_pc=0001, following fetch at 0001.
- Reset mid-WAIT: assert reset during WAIT → next cycle instr_valid=0 and raddr0=RESET_PC. First instruction is from RESET_PC.
